// File: rtl/port_comparator_pkg.sv
// Shared types and constants for the port comparator.
// Optional feature macro: PORTCMP_HIT_COUNT_EN.
package port_comparator_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PORT_W_DEF  = 16;
  localparam int NUM_OFFSETS = 7;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [PORT_W_DEF-1:0] port_t;

endpackage

// File: rtl/port_comparator_matcher.sv
// Byte-aligned 16-bit search over a 64-bit two-word window.
// Purely combinational; offsets 0..6 cover in-word and straddling ports.
module byte_window_matcher
  import port_comparator_pkg::*;
(
  input  logic [63:0] window,
  input  port_t       port,
  output logic        hit
);

  // OR of equality tests at every byte offset that fits a full port
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_OFFSETS; k++) begin
      if (window[8*k +: PORT_W_DEF] == port)
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/port_comparator.sv
// Stream port detector: sticky match flag plus 3-clock data delay.
// Define PORTCMP_HIT_COUNT_EN to add the saturating hit_count output.
module port_comparator
  import port_comparator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PORT_W = PORT_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [PORT_W-1:0] flagged_port,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
`ifdef PORTCMP_HIT_COUNT_EN
  output logic [7:0]        hit_count,
`endif
  output logic              match
);

  word_t r_cur;
  word_t r_prev;
  word_t r_d1;
  word_t r_d2;
  word_t r_out;
  logic  r_match;
  logic  w_hit;

  // Search window and delay line; zeroed state still gets compared
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      r_cur  <= '0;
      r_prev <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_out  <= '0;
    end else begin
      r_cur  <= data_in;
      r_prev <= r_cur;
      r_d1   <= data_in;
      r_d2   <= r_d1;
      r_out  <= r_d2;
    end
  end

  byte_window_matcher u_match (
    .window (({r_cur, r_prev})),
    .port   (flagged_port),
    .hit    (w_hit)
  );

  // Sticky flag; clear beats a hit in the same cycle
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_match <= 1'b0;
    end else if (clear) begin
      r_match <= 1'b0;
    end else begin
      r_match <= r_match | w_hit;
    end
  end

`ifdef PORTCMP_HIT_COUNT_EN
  logic [7:0] r_cnt;

  // Count hit cycles, holding at 255
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign hit_count = r_cnt;
`endif

  assign data_out = r_out;
  assign match    = r_match;

endmodule

// File: tb/tb_port_comparator.sv
// Directed bench for port_comparator.
// Builds with or without PORTCMP_HIT_COUNT_EN.
module tb_port_comparator;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic [15:0] flagged_port;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        match;
`ifdef PORTCMP_HIT_COUNT_EN
  logic [7:0]  hit_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  port_comparator dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .flagged_port (flagged_port),
    .data_in      (data_in),
    .data_out     (data_out),
`ifdef PORTCMP_HIT_COUNT_EN
    .hit_count    (hit_count),
`endif
    .match        (match)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] w);
    data_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(32'h0);
    clear = 1'b0;
  endtask

  initial begin
    n_rst        = 1'b0;
    clear        = 1'b0;
    flagged_port = 16'hABCD;
    data_in      = 32'h0;

    // reset
    step(32'h0);
    step(32'h0);
    chk("rst_m", {31'b0, match}, 32'h0);
    chk("rst_d", data_out, 32'h0);
    n_rst = 1'b1;
`ifdef PORTCMP_HIT_COUNT_EN
    chk("rst_cnt", {24'b0, hit_count}, 32'h0);
`endif

    // aligned in-word hit
    step(32'h00AB_CD00);
    chk("al_m0", {31'b0, match}, 32'h0);
    step(32'h0);
    step(32'h0);
    chk("al_m1", {31'b0, match}, 32'h1);
    chk("al_d", data_out, 32'h00AB_CD00);
    step(32'h0);
    chk("al_d0", data_out, 32'h0);
`ifdef PORTCMP_HIT_COUNT_EN
    chk("al_cnt", {24'b0, hit_count}, 32'd2);
`endif

    // clear after match
    do_clear();
    chk("clr_m", {31'b0, match}, 32'h0);
    chk("clr_d", data_out, 32'h0);

    // low half
    step(32'h0);
    step(32'h0000_ABCD);
    step(32'h0);
    chk("lo_d0", data_out, 32'h0);
    step(32'h0);
    chk("lo_m", {31'b0, match}, 32'h1);
    chk("lo_d1", data_out, 32'h0000_ABCD);
    do_clear();

    // high half
    step(32'hABCD_0000);
    step(32'h0);
    step(32'h0);
    chk("hi_m", {31'b0, match}, 32'h1);
    do_clear();

    // straddle across two words
    step(32'hCD00_0000);
    step(32'h0000_00AB);
    chk("st_m0", {31'b0, match}, 32'h0);
    step(32'h0);
    chk("st_m1", {31'b0, match}, 32'h1);
    chk("st_d0", data_out, 32'hCD00_0000);
    step(32'h0);
    chk("st_d1", data_out, 32'h0000_00AB);
    step(32'h0);
    chk("st_d2", data_out, 32'h0);
    do_clear();

    // nibble-shifted occurrences must not hit
    step(32'h0ABC_D000);
    step(32'h000A_BCD0);
    step(32'h0);
    step(32'h0);
    chk("na_m", {31'b0, match}, 32'h0);
    do_clear();

    // all-ones
    flagged_port = 16'hFFFF;
    step(32'hFFFF_FFFF);
    step(32'hFFFF_FFFF);
    step(32'h0);
    chk("ff_m", {31'b0, match}, 32'h1);
    do_clear();

    // zero port against zeroed state
    flagged_port = 16'h0000;
    step(32'h0);
    step(32'h0);
    chk("zz_m", {31'b0, match}, 32'h1);
    flagged_port = 16'hABCD;
    do_clear();

    // hit coincident with clear is dropped
    step(32'h0000_ABCD);
    clear = 1'b1;
    step(32'h0);
    clear = 1'b0;
    chk("cc_m0", {31'b0, match}, 32'h0);
    step(32'h0);
    chk("cc_m1", {31'b0, match}, 32'h0);

    // reset discards an in-flight word
    step(32'h00AB_CD00);
    n_rst = 1'b0;
    step(32'h0);
    n_rst = 1'b1;
    chk("rr_m0", {31'b0, match}, 32'h0);
    step(32'h0);
    step(32'h0);
    chk("rr_m1", {31'b0, match}, 32'h0);
    chk("rr_d", data_out, 32'h0);

    // port change takes effect from the next edge only
    flagged_port = 16'h1234;
    step(32'h0000_ABCD);
    step(32'h0);
    chk("fp_m0", {31'b0, match}, 32'h0);
    flagged_port = 16'hABCD;
    step(32'h0);
    chk("fp_m1", {31'b0, match}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
